test_access_ctrl: RTL and testbench

Parametrised test-access controller for the transceiver datapath (inFIFO → coder → decoder → CORDIC → CDR → outFIFO). It sits between NCH functional inter-block channels, each W bits wide, and the chip test pins. It is configured over a serial shadow register and has four modes: bypass, observe, inject and capture. It replaces fixed per-signal pin muxing with a chainable config register and an on-chip capture buffer of DEPTH samples that can be read back later.

---
 rtl/test_access_ctrl_if.sv | 46 ++++
 rtl/test_access_ctrl.sv | 164 ++++++++++++++++
 tb/tb_test_access_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/test_access_ctrl_if.sv
// Bundle of the test-access controller's config, functional, observe and
// capture-readback signals. The bench (master) drives the inputs and the
// controller (slave) drives the outputs.
interface test_access_ctrl_if #(
  parameter int unsigned NCH   = 8,
  parameter int unsigned W     = 4,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CNTW = $clog2(DEPTH + 1);

  logic              inCfgShift;
  logic              inCfgData;
  logic              inCfgUpdate;
  logic              outCfgData;
  logic [1:0]        outMode;
  logic              outCfgErr;
  logic [NCH*W-1:0]  inFuncData;
  logic [NCH-1:0]    inProbeValid;
  logic [W-1:0]      inInjData;
  logic [NCH*W-1:0]  outFuncData;
  logic [W-1:0]      outObsData;
  logic              outObsValid;
  logic              inRdEn;
  logic [W-1:0]      outRdData;
  logic              outRdValid;
  logic [CNTW-1:0]   outCapCount;
  logic              outCapFull;
  logic              outCapEmpty;
  logic              outRdErr;

  modport master (
    output inCfgShift, inCfgData, inCfgUpdate, inFuncData, inProbeValid,
           inInjData, inRdEn,
    input  outCfgData, outMode, outCfgErr, outFuncData, outObsData,
           outObsValid, outRdData, outRdValid, outCapCount, outCapFull,
           outCapEmpty, outRdErr
  );

  modport slave (
    input  inCfgShift, inCfgData, inCfgUpdate, inFuncData, inProbeValid,
           inInjData, inRdEn,
    output outCfgData, outMode, outCfgErr, outFuncData, outObsData,
           outObsValid, outRdData, outRdValid, outCapCount, outCapFull,
           outCapEmpty, outRdErr
  );
endinterface

// File: rtl/test_access_ctrl.sv
// Test-access controller: serial shadow/active config register, per-channel
// bypass/observe/inject/capture muxing and a DEPTH-entry capture FIFO that
// can be read back in any mode.
module test_access_ctrl #(
  parameter int unsigned NCH   = 8,
  parameter int unsigned W     = 4,
  parameter int unsigned DEPTH = 16
) (
  input logic inClock,
  input logic inReset,
  test_access_ctrl_if.slave bus
);
  localparam int unsigned SELW = $clog2(NCH);
  localparam int unsigned CW   = SELW + 2;
  localparam int unsigned PTRW = $clog2(DEPTH);
  localparam int unsigned CNTW = $clog2(DEPTH + 1);

  localparam logic [1:0] MODE_BYPASS  = 2'b00;
  localparam logic [1:0] MODE_OBSERVE = 2'b01;
  localparam logic [1:0] MODE_INJECT  = 2'b10;
  localparam logic [1:0] MODE_CAPTURE = 2'b11;

  localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(DEPTH);

  logic [CW-1:0]   shadow;
  logic [1:0]      actMode;
  logic [SELW-1:0] actSel;
  logic            cfgErr;
  logic [1:0]      effMode;
  logic [W-1:0]    selData;
  logic            selValid;

  logic [W-1:0]    mem [DEPTH];
  logic [PTRW-1:0] wrPtr;
  logic [PTRW-1:0] rdPtr;
  logic [CNTW-1:0] count;
  logic            capClear;
  logic            capWrite;
  logic            capRead;

  logic [W-1:0]    obsData;
  logic            obsValid;
  logic [W-1:0]    rdData;
  logic            rdValid;
  logic            rdErr;

  // Shadow shifts LSB-first; update copies the pre-shift shadow into active.
  always_ff @(posedge inClock) begin
    if (inReset) begin
      shadow  <= '0;
      actMode <= MODE_BYPASS;
      actSel  <= '0;
    end else begin
      if (bus.inCfgShift)
        shadow <= {bus.inCfgData, shadow[CW-1:1]};
      if (bus.inCfgUpdate)
        {actMode, actSel} <= shadow;
    end
  end

  // Out-of-range select only exists when NCH is not a power of two.
  generate
    if (NCH == (1 << SELW)) begin : gNoErr
      assign cfgErr = 1'b0;
    end else begin : gErr
      assign cfgErr = (actSel >= SELW'(NCH));
    end
  endgenerate

  // Effective mode collapses to bypass on a config error.
  always_comb begin
    effMode = cfgErr ? MODE_BYPASS : actMode;
  end

  // Selected channel data/valid, mux written as a compare loop so an invalid
  // select never indexes past the bus.
  always_comb begin
    selData  = '0;
    selValid = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (actSel == SELW'(i)) begin
        selData  = bus.inFuncData[i*W +: W];
        selValid = bus.inProbeValid[i];
      end
    end
  end

  // Functional path: pass-through, with the selected channel replaced in INJECT.
  always_comb begin
    bus.outFuncData = bus.inFuncData;
    if (effMode == MODE_INJECT) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (actSel == SELW'(i))
          bus.outFuncData[i*W +: W] = bus.inInjData;
      end
    end
  end

  // Observe register: one-cycle sampled copy of the selected channel.
  always_ff @(posedge inClock) begin
    if (inReset || effMode != MODE_OBSERVE) begin
      obsData  <= '0;
      obsValid <= 1'b0;
    end else begin
      obsData  <= selData;
      obsValid <= selValid;
    end
  end

  assign capClear = bus.inCfgUpdate && (shadow[CW-1 -: 2] == MODE_CAPTURE);
  assign capWrite = (effMode == MODE_CAPTURE) && selValid && (count != FULL_COUNT);
  assign capRead  = bus.inRdEn && (count != '0);

  // Capture FIFO control; a capture re-arm overrides any same-edge write/read.
  always_ff @(posedge inClock) begin
    if (inReset) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      count   <= '0;
      rdData  <= '0;
      rdValid <= 1'b0;
      rdErr   <= 1'b0;
    end else if (capClear) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      count   <= '0;
      rdValid <= 1'b0;
      rdErr   <= 1'b0;
    end else begin
      rdValid <= capRead;
      if (capRead) begin
        rdData <= mem[rdPtr];
        rdPtr  <= rdPtr + 1'b1;
      end
      if (bus.inRdEn && !capRead)
        rdErr <= 1'b1;
      if (capWrite)
        wrPtr <= wrPtr + 1'b1;
      case ({capWrite, capRead})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Capture storage, not reset.
  always_ff @(posedge inClock) begin
    if (!inReset && !capClear && capWrite)
      mem[wrPtr] <= selData;
  end

  assign bus.outCfgData  = shadow[0];
  assign bus.outMode     = actMode;
  assign bus.outCfgErr   = cfgErr;
  assign bus.outObsData  = obsData;
  assign bus.outObsValid = obsValid;
  assign bus.outRdData   = rdData;
  assign bus.outRdValid  = rdValid;
  assign bus.outRdErr    = rdErr;
  assign bus.outCapCount = count;
  assign bus.outCapFull  = (count == FULL_COUNT);
  assign bus.outCapEmpty = (count == '0);
endmodule

// File: tb/tb_test_access_ctrl.sv
// Self-checking bench for test_access_ctrl: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_test_access_ctrl;
  localparam int unsigned NCH   = 8;
  localparam int unsigned W     = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned SELW  = 3;
  localparam int unsigned CW    = 5;
  localparam int unsigned NCH2  = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  test_access_ctrl_if #(.NCH(NCH),  .W(W), .DEPTH(DEPTH)) bus ();
  test_access_ctrl_if #(.NCH(NCH2), .W(W), .DEPTH(DEPTH)) bus2 ();

  test_access_ctrl #(.NCH(NCH),  .W(W), .DEPTH(DEPTH)) dut  (.inClock(clk), .inReset(rst), .bus(bus));
  test_access_ctrl #(.NCH(NCH2), .W(W), .DEPTH(DEPTH)) dut2 (.inClock(clk), .inReset(rst), .bus(bus2));

  // Reference model state
  logic [CW-1:0]   mShadow;
  logic [1:0]      mMode;
  logic [SELW-1:0] mSel;
  logic [W-1:0]    mObsData;
  logic            mObsValid;
  logic [W-1:0]    mRdData;
  logic            mRdValid;
  logic            mRdErr;
  logic [W-1:0]    q[$];

  task automatic modelEdge();
    logic [1:0] eff;
    logic [W-1:0] chan;
    logic clr, wr, rd;
    if (rst) begin
      mShadow = '0; mMode = '0; mSel = '0; q.delete();
      mObsData = '0; mObsValid = 1'b0; mRdData = '0; mRdValid = 1'b0; mRdErr = 1'b0;
      return;
    end
    eff  = (int'(mSel) >= NCH) ? 2'd0 : mMode;
    chan = bus.inFuncData[mSel*W +: W];
    mObsData  = (eff == 2'd1) ? chan : '0;
    mObsValid = (eff == 2'd1) ? bus.inProbeValid[mSel] : 1'b0;
    clr = bus.inCfgUpdate && (mShadow[CW-1 -: 2] == 2'd3);
    wr  = (eff == 2'd3) && bus.inProbeValid[mSel] && (q.size() < DEPTH);
    rd  = bus.inRdEn && (q.size() > 0);
    if (clr) begin
      q.delete(); mRdErr = 1'b0; mRdValid = 1'b0;
    end else begin
      mRdValid = rd;
      if (rd) mRdData = q.pop_front();
      if (bus.inRdEn && !rd) mRdErr = 1'b1;
      if (wr) q.push_back(chan);
    end
    if (bus.inCfgUpdate) {mMode, mSel} = mShadow;
    if (bus.inCfgShift) mShadow = {bus.inCfgData, mShadow[CW-1:1]};
  endtask

  function automatic logic [NCH*W-1:0] expFunc();
    logic [NCH*W-1:0] r;
    r = bus.inFuncData;
    if (int'(mSel) < NCH && mMode == 2'd2) r[mSel*W +: W] = bus.inInjData;
    return r;
  endfunction

  task automatic cycle();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIns();
    bus.inCfgShift = 0; bus.inCfgData = 0; bus.inCfgUpdate = 0;
    bus.inFuncData = '0; bus.inProbeValid = '0; bus.inInjData = '0; bus.inRdEn = 0;
    bus2.inCfgShift = 0; bus2.inCfgData = 0; bus2.inCfgUpdate = 0;
    bus2.inFuncData = '0; bus2.inProbeValid = '0; bus2.inInjData = '0; bus2.inRdEn = 0;
  endtask

  task automatic loadCfg(input int mode, input int sel);
    int word;
    word = (mode << SELW) | sel;
    for (int i = 0; i < int'(CW); i++) begin
      bus.inCfgShift = 1; bus.inCfgData = 1'((word >> i) & 1);
      cycle();
    end
    bus.inCfgShift = 0; bus.inCfgUpdate = 1;
    cycle();
    bus.inCfgUpdate = 0;
  endtask

  task automatic loadCfg2(input int mode, input int sel);
    int word;
    word = (mode << SELW) | sel;
    for (int i = 0; i < int'(CW); i++) begin
      bus2.inCfgShift = 1; bus2.inCfgData = 1'((word >> i) & 1);
      cycle();
    end
    bus2.inCfgShift = 0; bus2.inCfgUpdate = 1;
    cycle();
    bus2.inCfgUpdate = 0;
  endtask

  task automatic test_reset();
    rst = 1; clearIns();
    cycle(); cycle();
    total++; if (bus.outMode !== 2'b00) $display("FAIL reset_mode: got %0h want 0", bus.outMode); else passed++;
    total++; if (bus.outCfgErr !== 1'b0) $display("FAIL reset_cfgErr: got %0b want 0", bus.outCfgErr); else passed++;
    total++; if (bus.outCfgData !== 1'b0) $display("FAIL reset_cfgData: got %0b want 0", bus.outCfgData); else passed++;
    total++; if (bus.outObsData !== 4'h0) $display("FAIL reset_obsData: got %0h want 0", bus.outObsData); else passed++;
    total++; if (bus.outObsValid !== 1'b0) $display("FAIL reset_obsValid: got %0b want 0", bus.outObsValid); else passed++;
    total++; if (bus.outRdData !== 4'h0) $display("FAIL reset_rdData: got %0h want 0", bus.outRdData); else passed++;
    total++; if (bus.outRdValid !== 1'b0) $display("FAIL reset_rdValid: got %0b want 0", bus.outRdValid); else passed++;
    total++; if (bus.outRdErr !== 1'b0) $display("FAIL reset_rdErr: got %0b want 0", bus.outRdErr); else passed++;
    total++; if (bus.outCapCount !== 5'd0) $display("FAIL reset_count: got %0d want 0", bus.outCapCount); else passed++;
    total++; if (bus.outCapEmpty !== 1'b1) $display("FAIL reset_empty: got %0b want 1", bus.outCapEmpty); else passed++;
    total++; if (bus.outCapFull !== 1'b0) $display("FAIL reset_full: got %0b want 0", bus.outCapFull); else passed++;
    rst = 0;
    cycle();
  endtask

  task automatic test_config_inject();
    logic [NCH*W-1:0] exp;
    loadCfg(2, 3);
    total++; if (bus.outMode !== 2'b10) $display("FAIL inject_mode: got %0h want 2", bus.outMode); else passed++;
    total++; if (bus.outCfgData !== 1'b1) $display("FAIL inject_cfgData: got %0b want 1", bus.outCfgData); else passed++;
    for (int i = 0; i < 4; i++) begin
      bus.inFuncData = $urandom; bus.inInjData = 4'hA;
      #1;
      exp = bus.inFuncData; exp[12 +: 4] = 4'hA;
      total++; if (bus.outFuncData !== exp) $display("FAIL inject_func: got %h want %h", bus.outFuncData, exp); else passed++;
    end
  endtask

  task automatic test_shift_update_same();
    for (int i = 0; i < int'(CW); i++) begin
      bus.inCfgShift = 1; bus.inCfgData = 1'(((5'b01_101) >> i) & 1);
      cycle();
    end
    bus.inCfgShift = 1; bus.inCfgData = 0; bus.inCfgUpdate = 1;
    cycle();
    bus.inCfgShift = 0; bus.inCfgUpdate = 0;
    total++; if (bus.outMode !== 2'b01) $display("FAIL same_cycle_mode: got %0h want 1", bus.outMode); else passed++;
    total++; if (bus.outCfgData !== 1'b0) $display("FAIL same_cycle_cfgData: got %0b want 0", bus.outCfgData); else passed++;
  endtask

  task automatic test_observe();
    bus.inFuncData = $urandom; bus.inFuncData[20 +: 4] = 4'h7; bus.inProbeValid = 8'h20;
    cycle();
    total++; if (bus.outObsData !== 4'h7) $display("FAIL observe_data: got %0h want 7", bus.outObsData); else passed++;
    total++; if (bus.outObsValid !== 1'b1) $display("FAIL observe_valid: got %0b want 1", bus.outObsValid); else passed++;
    for (int i = 0; i < 12; i++) begin
      bus.inFuncData = $urandom; bus.inProbeValid = 8'($urandom);
      cycle();
      total++; if (bus.outObsData !== mObsData || bus.outObsValid !== mObsValid)
        $display("FAIL observe_rand: got %0h/%0b want %0h/%0b", bus.outObsData, bus.outObsValid, mObsData, mObsValid);
      else passed++;
    end
    bus.inProbeValid = '0;
  endtask

  task automatic test_cfg_err();
    logic [NCH2*W-1:0] exp;
    bus2.inFuncData = '1; bus2.inProbeValid = '1; bus2.inInjData = 4'h5;
    loadCfg2(1, 7);
    cycle();
    total++; if (bus2.outCfgErr !== 1'b1) $display("FAIL err_flag: got %0b want 1", bus2.outCfgErr); else passed++;
    total++; if (bus2.outMode !== 2'b01) $display("FAIL err_mode: got %0h want 1", bus2.outMode); else passed++;
    total++; if (bus2.outObsData !== 4'h0 || bus2.outObsValid !== 1'b0)
      $display("FAIL err_obs: got %0h/%0b want 0/0", bus2.outObsData, bus2.outObsValid); else passed++;
    loadCfg2(2, 6);
    total++; if (bus2.outFuncData !== bus2.inFuncData) $display("FAIL err_bypass: got %h want %h", bus2.outFuncData, bus2.inFuncData); else passed++;
    total++; if (bus2.outCfgErr !== 1'b1) $display("FAIL err_sel6: got %0b want 1", bus2.outCfgErr); else passed++;
    loadCfg2(2, 5);
    exp = '1; exp[20 +: 4] = 4'h5;
    total++; if (bus2.outFuncData !== exp) $display("FAIL err_sel5_inject: got %h want %h", bus2.outFuncData, exp); else passed++;
    total++; if (bus2.outCfgErr !== 1'b0) $display("FAIL err_sel5_flag: got %0b want 0", bus2.outCfgErr); else passed++;
  endtask

  task automatic test_capture_fill();
    loadCfg(3, 2);
    total++; if (bus.outCapEmpty !== 1'b1) $display("FAIL fill_start_empty: got %0b want 1", bus.outCapEmpty); else passed++;
    for (int s = 1; s <= 20; s++) begin
      bus.inFuncData = $urandom; bus.inFuncData[8 +: 4] = 4'(s);
      bus.inProbeValid = 8'($urandom) | 8'h04;
      cycle();
      total++; if (int'(bus.outCapCount) != ((s < 16) ? s : 16) || bus.outCapFull !== (s >= 16))
        $display("FAIL fill_count: sample %0d got %0d/%0b want %0d/%0b", s, bus.outCapCount, bus.outCapFull, (s < 16) ? s : 16, s >= 16);
      else passed++;
    end
    bus.inProbeValid = '0;
  endtask

  task automatic test_readback();
    bus.inRdEn = 1;
    for (int k = 1; k <= 16; k++) begin
      cycle();
      total++; if (bus.outRdData !== 4'(k) || bus.outRdValid !== 1'b1)
        $display("FAIL readback_%0d: got %0h/%0b want %0h/1", k, bus.outRdData, bus.outRdValid, 4'(k));
      else passed++;
    end
    total++; if (bus.outCapEmpty !== 1'b1) $display("FAIL readback_empty: got %0b want 1", bus.outCapEmpty); else passed++;
    cycle();
    total++; if (bus.outRdValid !== 1'b0 || bus.outRdErr !== 1'b1)
      $display("FAIL readback_underflow: got valid %0b err %0b want 0/1", bus.outRdValid, bus.outRdErr); else passed++;
    bus.inRdEn = 0;
    cycle();
    total++; if (bus.outRdErr !== 1'b1 || bus.outRdData !== 4'h0)
      $display("FAIL readback_sticky: got err %0b data %0h want 1/0", bus.outRdErr, bus.outRdData); else passed++;
  endtask

  task automatic test_rearm();
    bus.inProbeValid = 8'h04;
    for (int s = 0; s < 16; s++) begin
      bus.inFuncData = $urandom;
      cycle();
    end
    bus.inProbeValid = '0;
    total++; if (bus.outCapCount !== 5'd16 || bus.outRdErr !== 1'b1)
      $display("FAIL rearm_before: got %0d/%0b want 16/1", bus.outCapCount, bus.outRdErr); else passed++;
    loadCfg(3, 2);
    total++; if (bus.outCapCount !== 5'd0 || bus.outRdErr !== 1'b0 || bus.outCapEmpty !== 1'b1)
      $display("FAIL rearm_after: got %0d/%0b/%0b want 0/0/1", bus.outCapCount, bus.outRdErr, bus.outCapEmpty); else passed++;
  endtask

  task automatic test_back_to_back();
    bus.inProbeValid = 8'h04;
    for (int s = 0; s < 10; s++) begin
      bus.inFuncData = $urandom;
      cycle();
    end
    bus.inRdEn = 1;
    for (int s = 0; s < 30; s++) begin
      bus.inFuncData = $urandom;
      cycle();
      total++; if (bus.outCapCount !== 5'd10 || bus.outRdValid !== 1'b1 || bus.outRdData !== mRdData)
        $display("FAIL b2b_%0d: got cnt %0d v %0b d %0h want 10/1/%0h", s, bus.outCapCount, bus.outRdValid, bus.outRdData, mRdData);
      else passed++;
    end
    bus.inRdEn = 0; bus.inProbeValid = '0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.inFuncData = $urandom; bus.inInjData = 4'($urandom);
      bus.inProbeValid = 8'($urandom);
      bus.inRdEn = ($urandom % 3 == 0);
      bus.inCfgShift = ($urandom % 4 == 0); bus.inCfgData = 1'($urandom);
      bus.inCfgUpdate = ($urandom % 12 == 0);
      cycle();
      total++; if (bus.outMode !== mMode || bus.outCfgData !== mShadow[0] || bus.outCfgErr !== 1'b0)
        $display("FAIL rand_cfg_%0d: got %0h/%0b want %0h/%0b", i, bus.outMode, bus.outCfgData, mMode, mShadow[0]); else passed++;
      total++; if (bus.outFuncData !== expFunc())
        $display("FAIL rand_func_%0d: got %h want %h", i, bus.outFuncData, expFunc()); else passed++;
      total++; if (bus.outObsData !== mObsData || bus.outObsValid !== mObsValid)
        $display("FAIL rand_obs_%0d: got %0h/%0b want %0h/%0b", i, bus.outObsData, bus.outObsValid, mObsData, mObsValid); else passed++;
      total++; if (bus.outRdData !== mRdData || bus.outRdValid !== mRdValid || bus.outRdErr !== mRdErr)
        $display("FAIL rand_rd_%0d: got %0h/%0b/%0b want %0h/%0b/%0b", i, bus.outRdData, bus.outRdValid, bus.outRdErr, mRdData, mRdValid, mRdErr); else passed++;
      total++; if (int'(bus.outCapCount) != q.size() || bus.outCapFull !== (q.size() == DEPTH) || bus.outCapEmpty !== (q.size() == 0))
        $display("FAIL rand_count_%0d: got %0d want %0d", i, bus.outCapCount, q.size()); else passed++;
    end
    clearIns();
  endtask

  task automatic test_reset_mid();
    loadCfg(3, 4);
    bus.inProbeValid = 8'h10;
    for (int s = 0; s < 7; s++) begin
      bus.inFuncData = $urandom;
      cycle();
    end
    total++; if (bus.outCapCount !== 5'd7) $display("FAIL midreset_pre: got %0d want 7", bus.outCapCount); else passed++;
    rst = 1;
    cycle();
    rst = 0;
    total++; if (bus.outCapCount !== 5'd0 || bus.outCapEmpty !== 1'b1 || bus.outCapFull !== 1'b0)
      $display("FAIL midreset_count: got %0d/%0b/%0b want 0/1/0", bus.outCapCount, bus.outCapEmpty, bus.outCapFull); else passed++;
    total++; if (bus.outMode !== 2'b00 || bus.outCfgData !== 1'b0 || bus.outRdValid !== 1'b0 || bus.outRdErr !== 1'b0 || bus.outObsValid !== 1'b0)
      $display("FAIL midreset_outs: got mode %0h cfg %0b rv %0b re %0b ov %0b want all 0", bus.outMode, bus.outCfgData, bus.outRdValid, bus.outRdErr, bus.outObsValid); else passed++;
    cycle();
    total++; if (bus.outCapCount !== 5'd0) $display("FAIL midreset_bypass: got %0d want 0", bus.outCapCount); else passed++;
    bus.inProbeValid = '0;
  endtask

  initial begin
    test_reset();
    test_config_inject();
    test_shift_update_same();
    test_observe();
    test_capture_fill();
    test_readback();
    test_rearm();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_cfg_err();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
